// File: rtl/count_range_mode.sv
// Up/down range counter with runtime limits, step size, load and
// wrap / saturate / bounce / one-shot end-of-range handling.
module count_range_mode #(
    parameter int WIDTH     = 8,
    parameter int LIM_L_DEF = 0,
    parameter int LIM_H_DEF = 99,
    parameter int STEP_W    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              direction,
    input  logic [1:0]        mode,
    input  logic [STEP_W-1:0] step,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic              lim_wr,
    input  logic [WIDTH-1:0]  lim_l_in,
    input  logic [WIDTH-1:0]  lim_h_in,
    output logic [WIDTH-1:0]  counter,
    output logic              dir_out,
    output logic              done,
    output logic              wrapped,
    output logic              running,
    output logic              lim_err
);

    typedef enum logic {S_RUN, S_HALT} state_t;

    localparam logic [1:0] M_WRAP = 2'd0;
    localparam logic [1:0] M_SAT  = 2'd1;
    localparam logic [1:0] M_BNC  = 2'd2;
    localparam logic [1:0] M_ONE  = 2'd3;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] lim_l_q, lim_l_d;
    logic [WIDTH-1:0] lim_h_q, lim_h_d;
    logic             bdir_q, bdir_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;

    logic              up, over, out_rng, halted;
    logic [STEP_W-1:0] s_eff;
    logic [WIDTH:0]    s_ext, c_ext, sum, diff, lo_s, nxt;
    logic [WIDTH-1:0]  lim_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RUN;
            cnt_q   <= WIDTH'(LIM_L_DEF);
            lim_l_q <= WIDTH'(LIM_L_DEF);
            lim_h_q <= WIDTH'(LIM_H_DEF);
            bdir_q  <= 1'b1;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lim_l_q <= lim_l_d;
            lim_h_q <= lim_h_d;
            bdir_q  <= bdir_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    // Arithmetic is one bit wider so overshoot never wraps modulo 2**WIDTH
    always_comb begin
        up      = (mode == M_BNC) ? bdir_q : direction;
        s_eff   = (step == '0) ? STEP_W'(1) : step;
        s_ext   = (WIDTH+1)'(s_eff);
        c_ext   = {1'b0, cnt_q};
        sum     = c_ext + s_ext;
        diff    = c_ext - s_ext;
        lo_s    = {1'b0, lim_l_q} + s_ext;
        over    = up ? (sum > {1'b0, lim_h_q}) : (c_ext < lo_s);
        nxt     = up ? sum : diff;
        lim_hit = up ? lim_h_q : lim_l_q;
        out_rng = (cnt_q < lim_l_q) || (cnt_q > lim_h_q);
        halted  = (state_q == S_HALT) && (mode == M_ONE);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lim_l_d = lim_l_q;
        lim_h_d = lim_h_q;
        bdir_d  = bdir_q;
        wrap_d  = 1'b0;
        err_d   = 1'b0;
        if (state_q == S_HALT && mode != M_ONE)
            state_d = S_RUN;
        if (load) begin
            cnt_d   = load_val;
            bdir_d  = direction;
            state_d = S_RUN;
        end else if (lim_wr) begin
            if (lim_l_in <= lim_h_in) begin
                lim_l_d = lim_l_in;
                lim_h_d = lim_h_in;
            end else begin
                err_d = 1'b1;
            end
        end else if (enable && !halted) begin
            if (out_rng) begin
                cnt_d = lim_l_q;
            end else if (!over) begin
                cnt_d = nxt[WIDTH-1:0];
                // Bounce turns around on landing exactly on a limit
                if (mode == M_BNC && nxt == {1'b0, lim_hit}) begin
                    bdir_d = ~bdir_q;
                    wrap_d = 1'b1;
                end
            end else begin
                unique case (1'b1)
                    mode == M_WRAP: begin
                        cnt_d  = up ? lim_l_q : lim_h_q;
                        wrap_d = 1'b1;
                    end
                    mode == M_SAT: begin
                        cnt_d  = lim_hit;
                        wrap_d = (cnt_q != lim_hit);
                    end
                    mode == M_BNC: begin
                        cnt_d  = lim_hit;
                        bdir_d = ~bdir_q;
                        wrap_d = 1'b1;
                    end
                    mode == M_ONE: begin
                        cnt_d   = lim_hit;
                        state_d = S_HALT;
                        wrap_d  = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign counter = cnt_q;
    assign dir_out = up;
    assign wrapped = wrap_q;
    assign lim_err = err_q;
    assign running = (state_q == S_RUN);
    assign done    = (up && cnt_q == lim_h_q) || (!up && cnt_q == lim_l_q);

endmodule

// File: tb/tb_count_range_mode.sv
// Scoreboard bench for count_range_mode: driver queues expected
// outputs, monitor compares them one cycle after each edge.
module tb_count_range_mode;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable, direction, load, lim_wr;
    logic [1:0] mode;
    logic [3:0] step;
    logic [7:0] load_val, lim_l_in, lim_h_in;
    logic [7:0] counter;
    logic       dir_out, done, wrapped, running, lim_err;

    typedef struct {
        int         idx;
        logic [7:0] c;
        logic       d, w, r, e, dn;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   vec      = 0;

    count_range_mode dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .direction(direction), .mode(mode), .step(step),
        .load(load), .load_val(load_val), .lim_wr(lim_wr),
        .lim_l_in(lim_l_in), .lim_h_in(lim_h_in),
        .counter(counter), .dir_out(dir_out), .done(done),
        .wrapped(wrapped), .running(running), .lim_err(lim_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int i,
                       input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s vec=%0d actual=%0d required=%0d",
                     nm, i, act, req);
        end
    endtask

    // Monitor: outputs are valid every cycle after the edge
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                chk("counter", x.idx, counter, x.c);
                chk("dir_out", x.idx, 8'(dir_out), 8'(x.d));
                chk("wrapped", x.idx, 8'(wrapped), 8'(x.w));
                chk("running", x.idx, 8'(running), 8'(x.r));
                chk("lim_err", x.idx, 8'(lim_err), 8'(x.e));
                chk("done", x.idx, 8'(done), 8'(x.dn));
            end
        end
    end

    task automatic cy(input logic en, ld, lw, dir,
                      input logic [1:0] md, input logic [3:0] st,
                      input logic [7:0] v, ll, lh,
                      input logic [7:0] ec,
                      input logic ed, ew, er, ee, edn);
        exp_t x;
        @(negedge clk);
        enable    = en;
        load      = ld;
        lim_wr    = lw;
        direction = dir;
        mode      = md;
        step      = st;
        load_val  = v;
        lim_l_in  = ll;
        lim_h_in  = lh;
        x.idx = vec; x.c = ec; x.d = ed; x.w = ew;
        x.r = er; x.e = ee; x.dn = edn;
        q.push_back(x);
        vec++;
        @(posedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        enable = 0; load = 0; lim_wr = 0; direction = 1;
        mode = 0; step = 0; load_val = 0;
        lim_l_in = 0; lim_h_in = 0;
        #2;
        chk("rst_counter", -1, counter, 8'd0);
        chk("rst_running", -1, 8'(running), 8'd1);
        @(negedge clk);
        rst_n = 1'b1;

        //  en ld lw dir md st  val  ll  lh    cnt  d  w  r  e  dn
        cy(0, 1, 0, 1, 0, 1, 57, 0, 0,   57, 1, 0, 1, 0, 0);
        cy(1, 0, 0, 1, 0, 1, 0, 0, 0,    58, 1, 0, 1, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_counter", -2, counter, 8'd0);
        chk("arst_running", -2, 8'(running), 8'd1);
        chk("arst_dir_out", -2, 8'(dir_out), 8'd1);
        chk("arst_wrapped", -2, 8'(wrapped), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        enable = 0;

        // wrap up, step 3
        cy(0, 1, 0, 1, 0, 3, 96, 0, 0,   96, 1, 0, 1, 0, 0);
        cy(1, 0, 0, 1, 0, 3, 0, 0, 0,    99, 1, 0, 1, 0, 1);
        cy(1, 0, 0, 1, 0, 3, 0, 0, 0,     0, 1, 1, 1, 0, 0);
        cy(1, 0, 0, 1, 0, 3, 0, 0, 0,     3, 1, 0, 1, 0, 0);
        // saturate down, step 5
        cy(0, 1, 0, 0, 1, 5, 7, 0, 0,     7, 0, 0, 1, 0, 0);
        cy(1, 0, 0, 0, 1, 5, 0, 0, 0,     2, 0, 0, 1, 0, 0);
        cy(1, 0, 0, 0, 1, 5, 0, 0, 0,     0, 0, 1, 1, 0, 1);
        cy(1, 0, 0, 0, 1, 5, 0, 0, 0,     0, 0, 0, 1, 0, 1);
        // bounce between 10 and 13
        cy(0, 0, 1, 0, 1, 1, 0, 10, 13,   0, 0, 0, 1, 0, 0);
        cy(0, 1, 0, 1, 2, 1, 10, 0, 0,   10, 1, 0, 1, 0, 0);
        cy(1, 0, 0, 0, 2, 1, 0, 0, 0,    11, 1, 0, 1, 0, 0);
        cy(1, 0, 0, 0, 2, 1, 0, 0, 0,    12, 1, 0, 1, 0, 0);
        cy(1, 0, 0, 0, 2, 1, 0, 0, 0,    13, 0, 1, 1, 0, 0);
        cy(1, 0, 0, 0, 2, 1, 0, 0, 0,    12, 0, 0, 1, 0, 0);
        cy(1, 0, 0, 0, 2, 1, 0, 0, 0,    11, 0, 0, 1, 0, 0);
        cy(1, 0, 0, 0, 2, 1, 0, 0, 0,    10, 1, 1, 1, 0, 0);
        cy(1, 0, 0, 0, 2, 1, 0, 0, 0,    11, 1, 0, 1, 0, 0);
        // one-shot up from 97
        cy(0, 0, 1, 1, 3, 1, 0, 0, 99,   11, 1, 0, 1, 0, 0);
        cy(0, 1, 0, 1, 3, 1, 97, 0, 0,   97, 1, 0, 1, 0, 0);
        cy(1, 0, 0, 1, 3, 1, 0, 0, 0,    98, 1, 0, 1, 0, 0);
        cy(1, 0, 0, 1, 3, 1, 0, 0, 0,    99, 1, 0, 1, 0, 1);
        cy(1, 0, 0, 1, 3, 1, 0, 0, 0,    99, 1, 1, 0, 0, 1);
        cy(1, 0, 0, 1, 3, 1, 0, 0, 0,    99, 1, 0, 0, 0, 1);
        cy(0, 1, 0, 1, 3, 1, 5, 0, 0,     5, 1, 0, 1, 0, 0);
        // rejected then accepted limit writes
        cy(0, 0, 1, 1, 0, 1, 0, 50, 20,   5, 1, 0, 1, 1, 0);
        cy(1, 0, 0, 1, 0, 1, 0, 0, 0,     6, 1, 0, 1, 0, 0);
        cy(0, 1, 0, 1, 0, 1, 99, 0, 0,   99, 1, 0, 1, 0, 1);
        cy(0, 0, 1, 1, 0, 1, 0, 20, 50,  99, 1, 0, 1, 0, 0);
        cy(1, 0, 0, 1, 0, 1, 0, 0, 0,    20, 1, 0, 1, 0, 0);
        cy(0, 0, 0, 1, 0, 1, 0, 0, 0,    20, 1, 0, 1, 0, 0);

        for (int i = 0; i < 10 && q.size() > 0; i++)
            @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
